// File: rtl/aha_axi_to_sif_burst.sv
// Combinational AXI burst address step: FIXED holds, INCR aligns then advances, WRAP folds inside span.
// Latency 0; no flow control.
module aha_axi_addr_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] span;

  always_comb begin
    bytes = ADDR_WIDTH'(1) << size;
    span  = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~(span - ADDR_WIDTH'(1))) | ((addr + bytes) & (span - ADDR_WIDTH'(1)));
      default: next_addr = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    endcase
  end
endmodule

// Generic synchronous FIFO, head visible combinationally.
// Latency 1 (push to head); push is dropped when full, pop ignored when empty.
module aha_sif_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     core_clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push_vld && (count != CW'(DEPTH));
  assign do_pop   = pop_rdy && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge core_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// AXI4 slave to SIF bridge with independent write and read burst engines.
// Latency: W beat -> SIF write +1, AR -> SIF read +1, SIF return -> RVALID +1.
// Backpressure: read issue is credit-limited by RD_FIFO_DEPTH tags; RREADY stalls are absorbed.
module aha_axi_to_sif_burst #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [ADDR_WIDTH-1:0]   SIF_WR_ADDR,
  output logic                    SIF_WR_EN,
  output logic [DATA_WIDTH/8-1:0] SIF_WR_STRB,
  output logic [DATA_WIDTH-1:0]   SIF_WR_DATA,
  output logic [ADDR_WIDTH-1:0]   SIF_RD_ADDR,
  output logic                    SIF_RD_EN,
  input  logic [DATA_WIDTH-1:0]   SIF_RD_DATA,
  input  logic                    SIF_RD_VALID
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);
  localparam int CNT_W    = $clog2(RD_FIFO_DEPTH) + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_ISSUE = 1'b1;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                last;
    logic [1:0]          resp;
  } tag_t;

  function automatic logic burst_illegal(input logic [2:0] size, input logic [7:0] len,
                                         input logic [1:0] burst);
    logic wrap_bad;
    wrap_bad = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size > 3'(SIZE_MAX)) || (burst == 2'b11) || wrap_bad;
  endfunction

  // ---------------- write path ----------------
  logic [1:0]            w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_last_err;
  logic                  w_beat_last;

  aha_axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_agen (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_next)
  );

  assign AWREADY     = (w_state == W_IDLE) && ARESETn;
  assign WREADY      = (w_state == W_DATA);
  assign BVALID      = (w_state == W_RESP);
  assign w_beat_last = (w_cnt == w_len);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state     <= W_IDLE;
      w_id        <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_size      <= '0;
      w_burst     <= '0;
      w_err       <= 1'b0;
      w_last_err  <= 1'b0;
      BID         <= '0;
      BRESP       <= RESP_OKAY;
      SIF_WR_EN   <= 1'b0;
      SIF_WR_ADDR <= '0;
      SIF_WR_DATA <= '0;
      SIF_WR_STRB <= '0;
    end else begin
      SIF_WR_EN <= 1'b0;
      case (w_state)
        W_IDLE: if (AWVALID) begin
          w_id       <= AWID;
          w_addr     <= AWADDR;
          w_len      <= AWLEN;
          w_size     <= AWSIZE;
          w_burst    <= AWBURST;
          w_err      <= burst_illegal(AWSIZE, AWLEN, AWBURST);
          w_cnt      <= '0;
          w_last_err <= 1'b0;
          w_state    <= W_DATA;
        end
        W_DATA: if (WVALID) begin
          if (!w_err) begin
            SIF_WR_EN   <= 1'b1;
            SIF_WR_ADDR <= w_addr;
            SIF_WR_DATA <= WDATA;
            SIF_WR_STRB <= WSTRB;
          end
          w_addr <= w_next;
          w_cnt  <= w_cnt + 8'd1;
          // Beat count, not WLAST, closes the burst; WLAST disagreement only taints the response.
          if (w_beat_last) begin
            w_state <= W_RESP;
            BID     <= w_id;
            BRESP   <= (w_err || w_last_err || !WLAST) ? RESP_SLVERR : RESP_OKAY;
          end else if (WLAST) begin
            w_last_err <= 1'b1;
          end
        end
        W_RESP: if (BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  logic [0:0]            r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic                  r_idle;
  logic                  ar_err;
  logic [ID_WIDTH-1:0]   iss_id;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [ADDR_WIDTH-1:0] iss_next;
  logic [7:0]            iss_len;
  logic [7:0]            iss_cnt;
  logic [2:0]            iss_size;
  logic [1:0]            iss_burst;
  logic                  iss_err;
  logic                  iss_last;
  logic                  issue;

  tag_t                  tag_push;
  tag_t                  tag_head;
  logic [CNT_W-1:0]      tag_cnt;
  logic [DATA_WIDTH-1:0] dat_head;
  logic [CNT_W-1:0]      dat_cnt;
  logic                  head_err;
  logic                  r_hs;

  assign r_idle  = (r_state == R_IDLE);
  assign ARREADY = r_idle && ARESETn;
  assign ar_err  = burst_illegal(ARSIZE, ARLEN, ARBURST);

  // The first beat issues straight from the AR channel so SIF_RD_EN follows the handshake by one cycle.
  assign iss_id    = r_idle ? ARID    : r_id;
  assign iss_addr  = r_idle ? ARADDR  : r_addr;
  assign iss_len   = r_idle ? ARLEN   : r_len;
  assign iss_size  = r_idle ? ARSIZE  : r_size;
  assign iss_burst = r_idle ? ARBURST : r_burst;
  assign iss_err   = r_idle ? ar_err  : r_err;
  assign iss_cnt   = r_idle ? 8'd0    : r_cnt;
  assign iss_last  = (iss_cnt == iss_len);
  assign issue     = (tag_cnt < CNT_W'(RD_FIFO_DEPTH)) && ((r_idle && ARVALID) || !r_idle);

  aha_axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_agen (
    .addr(iss_addr), .size(iss_size), .len(iss_len), .burst(iss_burst), .next_addr(iss_next)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state     <= R_IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_err       <= 1'b0;
      SIF_RD_EN   <= 1'b0;
      SIF_RD_ADDR <= '0;
    end else begin
      SIF_RD_EN <= 1'b0;
      if (issue && !iss_err) begin
        SIF_RD_EN   <= 1'b1;
        SIF_RD_ADDR <= iss_addr;
      end
      case (r_state)
        R_IDLE: if (ARVALID) begin
          r_id    <= ARID;
          r_len   <= ARLEN;
          r_size  <= ARSIZE;
          r_burst <= ARBURST;
          r_err   <= ar_err;
          if (issue) begin
            r_addr  <= iss_next;
            r_cnt   <= 8'd1;
            r_state <= iss_last ? R_IDLE : R_ISSUE;
          end else begin
            r_addr  <= ARADDR;
            r_cnt   <= 8'd0;
            r_state <= R_ISSUE;
          end
        end
        R_ISSUE: if (issue) begin
          r_addr <= iss_next;
          r_cnt  <= r_cnt + 8'd1;
          if (iss_last) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign tag_push.id   = iss_id;
  assign tag_push.last = iss_last;
  assign tag_push.resp = iss_err ? RESP_SLVERR : RESP_OKAY;

  aha_sif_fifo #(.WIDTH($bits(tag_t)), .DEPTH(RD_FIFO_DEPTH)) u_tag_fifo (
    .core_clk(ACLK), .rst_n(ARESETn),
    .push_vld(issue), .push_dat(tag_push),
    .pop_rdy(r_hs), .head_dat(tag_head), .count(tag_cnt)
  );

  aha_sif_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RD_FIFO_DEPTH)) u_dat_fifo (
    .core_clk(ACLK), .rst_n(ARESETn),
    .push_vld(SIF_RD_VALID), .push_dat(SIF_RD_DATA),
    .pop_rdy(r_hs && !head_err), .head_dat(dat_head), .count(dat_cnt)
  );

  // Error beats carry no SIF data, so they are released on the tag alone.
  assign head_err = (tag_head.resp == RESP_SLVERR);
  assign RVALID   = (tag_cnt != '0) && (head_err || (dat_cnt != '0));
  assign r_hs     = RVALID && RREADY;
  assign RID      = RVALID ? tag_head.id   : '0;
  assign RLAST    = RVALID && tag_head.last;
  assign RRESP    = RVALID ? tag_head.resp : RESP_OKAY;
  assign RDATA    = (RVALID && !head_err) ? dat_head : '0;
endmodule

// File: doc/aha_axi_to_sif_burst.md
# aha_axi_to_sif_burst

Parametrised AXI4-slave to simple-interface (SIF) bridge for the Garnet integration layer. Generalises the fixed 64-bit bridge: configurable data, address and ID widths, full FIXED/INCR/WRAP burst address generation, SLVERR reporting for illegal bursts, and a credit-limited read-return FIFO. Read data may come back after any SIF latency while RREADY stalls are absorbed. Sits between the SoC AXI interconnect and SIF-style memories/CSR banks.

## Interface
- DATA_WIDTH, 64, AXI/SIF data bits; power of two, 32..256.
- ADDR_WIDTH, 32, AXI/SIF address bits.
- ID_WIDTH, 4, AXI ID bits.
- RD_FIFO_DEPTH, 4, max read beats in flight plus buffered (power of two, >=2).

- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address; AWVALID in 1, AWREADY out 1.
- WDATA/WSTRB/WLAST  in  DATA_WIDTH/DATA_WIDTH/8/1  write data; WVALID in 1, WREADY out 1.
- BID/BRESP  out  ID_WIDTH/2  write response; BVALID out 1, BREADY in 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  as AW*; ARVALID in 1, ARREADY out 1.
- RID/RDATA/RRESP/RLAST  out  ID_WIDTH/DATA_WIDTH/2/1; RVALID out 1, RREADY in 1.
- SIF_WR_ADDR/SIF_WR_EN/SIF_WR_STRB/SIF_WR_DATA  out  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  registered write strobe port.
- SIF_RD_ADDR/SIF_RD_EN  out  ADDR_WIDTH/1  registered read request.
- SIF_RD_DATA/SIF_RD_VALID  in  DATA_WIDTH/1  read return, in request order, >=1 cycle after SIF_RD_EN.

## Operation
- Burst legality: SLVERR if (1<<SIZE) > DATA_WIDTH/8, BURST==2'b11, or WRAP with LEN not in {1,3,7,15}. Otherwise OKAY.
- Address generator (shared logic, one instance per path). bytes=1<<SIZE.
  - FIXED: address constant.
  - INCR: next = (addr & ~(bytes-1)) + bytes.
  - WRAP: span=bytes*(LEN+1), base=addr & ~(span-1); next = base | ((addr+bytes) & (span-1)).
  - Wraps modulo 2^ADDR_WIDTH; 4 KB crossing not checked.
- Write FSM: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1; AW handshake latches ID/addr/len/size/burst/error, goes to W_DATA.
  - W_DATA: WREADY=1. Each W handshake on a legal burst drives SIF_WR_EN=1 next cycle with current address, WDATA, WSTRB; address advances.
  - Illegal bursts: beats are sunk, SIF_WR_EN stays 0.
  - Burst ends on beat LEN+1 regardless of WLAST. WLAST mismatch (early or missing) forces BRESP=SLVERR; writes still performed.
  - W_RESP: BVALID=1 holding BID/BRESP until BREADY, then W_IDLE.
- Read FSM: R_IDLE, R_ISSUE.
  - R_IDLE: ARREADY=1; AR handshake latches burst, goes to R_ISSUE.
  - R_ISSUE: each cycle with credit (tag count < RD_FIFO_DEPTH) issues one beat. It pushes tag {ID, last, resp}. For legal bursts it also drives SIF_RD_EN=1 with SIF_RD_ADDR next cycle; illegal bursts issue no SIF read. After beat LEN+1, returns to R_IDLE.
  - Data FIFO (depth RD_FIFO_DEPTH) is pushed on SIF_RD_VALID.
  - RVALID = tag nonempty and (tag.resp==SLVERR or data nonempty).
  - RDATA = FIFO head, or 0 for error beats. Handshake pops tag, and data if non-error.
- Read and write paths fully independent; simultaneous AW and AR both accepted.

## Timing
- Reset values: AWREADY=0, ARREADY=0 during reset, 1 the first cycle after. All other outputs 0, FIFOs empty, FSMs idle.
- Reset mid-burst: bursts abandoned, no B/R responses generated. SIF_RD_VALID during or after reset for pre-reset requests is a system error; the SIF target must share the reset.
- Write: W handshake cycle N -> SIF_WR_EN at N+1. Last beat at N -> BVALID at N+1. Throughput 1 beat/cycle.
- Read: AR handshake at N -> SIF_RD_EN at N+1. With SIF latency 1, data is pushed at N+2 and RVALID at N+3. Throughput 1 beat/cycle when RREADY=1 and latency <= RD_FIFO_DEPTH-2.
- Credit rule: tag count never exceeds RD_FIFO_DEPTH; data FIFO can never overflow. A push and pop in the same cycle keeps the count.
- RVALID/BVALID once asserted stay asserted with stable payload until handshake.

## Test plan
- INCR write, AWADDR=0x100, LEN=3, SIZE=3 (64b) -> SIF_WR_EN 4 cycles at 0x100,0x108,0x110,0x118 with matching data/strb; BRESP=OKAY, BID=AWID.
- WRAP read, ARADDR=0x38, LEN=3, SIZE=3 -> SIF_RD_ADDR 0x38,0x20,0x28,0x30; RLAST on beat 4; RRESP=OKAY.
- Read with RREADY=0 for 20 cycles, LEN=7, RD_FIFO_DEPTH=4 -> exactly 4 SIF_RD_EN, then stall; all 8 beats delivered in order once RREADY=1.
- Illegal bursts: AWBURST=2'b11 LEN=1 -> no SIF_WR_EN, BRESP=2'b10. ARLEN=2 WRAP -> 3 beats of RDATA=0, RRESP=2'b10, no SIF_RD_EN.
- WLAST asserted on beat 2 of LEN=3 -> 4 writes performed, BRESP=SLVERR. Unaligned INCR 0x103 SIZE=2 -> addresses 0x103,0x104,0x108.
- ARESETn low mid read burst with 2 beats buffered -> next cycle RVALID=0, SIF_RD_EN=0; after release ARREADY=1 and a fresh burst completes normally.
